// File: rtl/fetch_pkg.sv
// Shared types and reset defaults for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;
    localparam logic [63:0] PC_STEP_DEFAULT  = 64'd4;

    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
    } fetch_data_t;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer parking a fetched {instr,pc} while decode is stalled.
module fetch_skid
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  fetch_data_t din,
    output fetch_data_t dout,
    output logic        valid
);

    fetch_data_t data_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

    // NOTE: the payload is deliberately not reset; valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (load) begin
            data_q <= din;
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, one outstanding bus request, registered
// output to decode, stall via skid buffer, redirect with stale-response drain.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT,
    parameter logic [63:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output fetch_data_t dataF,
    output logic        dataF_valid
);

    fetch_state_t state, state_n;
    logic [63:0]  pc, pc_n;
    logic [63:0]  stale_addr, stale_n;
    logic         out_free;
    logic         out_load;
    fetch_data_t  out_data;
    logic         skid_load, skid_unload, skid_clear, skid_valid;
    fetch_data_t  skid_din, skid_dout;

    assign out_free   = !dataF_valid || !stall;
    assign skid_din   = '{raw_instr: iresp_data, pc: pc};
    assign ireq_valid = !reset && (state != HOLD);
    assign ireq_addr  = (state == DRAIN) ? stale_addr : pc;

    fetch_skid u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (skid_clear),
        .din    (skid_din),
        .dout   (skid_dout),
        .valid  (skid_valid)
    );

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        stale_n     = stale_addr;
        out_load    = 1'b0;
        out_data    = skid_dout;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        if (redirect_valid) begin
            pc_n       = redirect_pc;
            skid_clear = 1'b1;
            case (state)
                FETCH: begin
                    if (!iresp_data_ok) begin
                        state_n = DRAIN;
                        stale_n = pc;
                    end
                end
                HOLD:  state_n = FETCH;
                // A stale response landing with the redirect still retires the old request.
                DRAIN: if (iresp_data_ok) state_n = FETCH;
                default: state_n = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (iresp_data_ok) begin
                        pc_n = pc + PC_STEP;
                        if (out_free) begin
                            out_load = 1'b1;
                            out_data = skid_din;
                        end else begin
                            skid_load = 1'b1;
                            state_n   = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_free) begin
                        out_load    = skid_valid;
                        skid_unload = 1'b1;
                        state_n     = FETCH;
                    end
                end
                DRAIN: if (iresp_data_ok) state_n = FETCH;
                default: state_n = FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= PC_RESET;
            stale_addr <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            stale_addr <= stale_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dataF       <= '0;
            dataF_valid <= 1'b0;
        end else if (redirect_valid) begin
            dataF_valid <= 1'b0;
        end else if (out_load) begin
            dataF       <= out_data;
            dataF_valid <= 1'b1;
        end else if (out_free) begin
            dataF_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus random stimulus
// checked against a transaction-level model of the fetch stage.
module tb_fetch;
    import fetch_pkg::*;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam logic [63:0] STEP   = 64'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    fetch_data_t dataF;
    logic        dataF_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Model: next fetch PC, parked instructions, output register, and whether
    // the request currently on the bus belongs to a squashed path.
    logic [63:0] m_pc;
    bit          m_stale;
    logic [63:0] m_stale_addr;
    fetch_data_t m_buf[$];
    bit          m_ov;
    fetch_data_t m_out;

    always #5 clk = ~clk;

    fetch dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .dataF          (dataF),
        .dataF_valid    (dataF_valid)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // The stage requests whenever nothing is parked waiting for decode.
    function automatic bit exp_ireq_valid();
        return !reset && (m_buf.size() == 0);
    endfunction

    task automatic model_update();
        bit free;
        bit loaded;
        fetch_data_t entry;
        if (reset) begin
            m_pc = RST_PC;
            m_stale = 0;
            m_stale_addr = '0;
            m_buf.delete();
            m_ov = 0;
            m_out = '0;
            return;
        end
        free = !m_ov || !stall;
        if (redirect_valid) begin
            if (m_buf.size() == 0 && !m_stale && !iresp_data_ok) begin
                m_stale = 1;
                m_stale_addr = m_pc;
            end
            m_pc = redirect_pc;
            m_buf.delete();
            m_ov = 0;
            return;
        end
        loaded = 0;
        if (m_buf.size() != 0) begin
            if (free) begin
                m_out = m_buf.pop_front();
                m_ov = 1;
                loaded = 1;
            end
        end else if (iresp_data_ok) begin
            if (m_stale) begin
                m_stale = 0;
            end else begin
                entry = '{raw_instr: iresp_data, pc: m_pc};
                if (free) begin
                    m_out = entry;
                    m_ov = 1;
                    loaded = 1;
                end else begin
                    m_buf.push_back(entry);
                end
                m_pc = m_pc + STEP;
            end
        end
        if (!loaded && free) m_ov = 0;
    endtask

    task automatic compare_all();
        bit iv;
        iv = exp_ireq_valid();
        check("ireq_valid", 128'(ireq_valid), 128'(iv));
        if (iv) check("ireq_addr", 128'(ireq_addr), 128'(m_stale ? m_stale_addr : m_pc));
        check("dataF_valid", 128'(dataF_valid), 128'(m_ov));
        if (m_ov) check("dataF", 128'(dataF), 128'(m_out));
    endtask

    task automatic tick(input bit rst, input bit ok, input logic [31:0] data,
                        input bit rv, input logic [63:0] rpc, input bit st);
        reset = rst;
        iresp_data_ok = ok;
        iresp_data = data;
        redirect_valid = rv;
        redirect_pc = rpc;
        stall = st;
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        @(negedge clk);
        // Reset state
        tick(1, 0, '0, 0, '0, 0);
        tick(1, 0, '0, 0, '0, 0);
        check("rst_dataF", 128'(dataF), 128'(0));
        check("rst_ireq_valid", 128'(ireq_valid), 128'(0));

        // 1: back-to-back responses
        tick(0, 0, '0, 0, '0, 0);
        check("t1_addr0", 128'(ireq_addr), 128'(64'h8000_0000));
        tick(0, 1, 32'h0000_0013, 0, '0, 0);
        check("t1_valid", 128'(dataF_valid), 128'(1));
        check("t1_addr1", 128'(ireq_addr), 128'(64'h8000_0004));
        tick(0, 1, 32'h0000_0013, 0, '0, 0);
        tick(0, 1, 32'h0000_0013, 0, '0, 0);
        check("t1_pc", 128'(dataF.pc), 128'(64'h8000_0008));

        // 2: response while decode stalls goes to HOLD
        tick(1, 0, '0, 0, '0, 0);
        tick(0, 0, '0, 0, '0, 0);
        tick(0, 1, 32'h0000_0013, 0, '0, 0);
        tick(0, 1, 32'h0010_0093, 0, '0, 1);
        check("t2_hold_ireq", 128'(ireq_valid), 128'(0));
        tick(0, 0, '0, 0, '0, 0);
        check("t2_dataF", 128'(dataF), 128'({32'h0010_0093, 64'h8000_0004}));
        check("t2_next_addr", 128'(ireq_addr), 128'(64'h8000_0008));

        // 3: redirect with a request in flight drains the stale response
        tick(0, 0, '0, 1, 64'h8000_1000, 0);
        check("t3_stale_addr", 128'(ireq_addr), 128'(64'h8000_0008));
        tick(0, 0, '0, 0, '0, 0);
        tick(0, 0, '0, 0, '0, 0);
        tick(0, 1, 32'hDEAD_BEEF, 0, '0, 0);
        check("t3_new_addr", 128'(ireq_addr), 128'(64'h8000_1000));
        check("t3_dropped", 128'(dataF_valid), 128'(0));

        // 4: redirect coinciding with a response
        tick(0, 1, 32'h1234_5678, 1, 64'h8000_2000, 0);
        check("t4_addr", 128'(ireq_addr), 128'(64'h8000_2000));
        check("t4_valid", 128'(dataF_valid), 128'(0));

        // 5: second redirect during DRAIN
        tick(0, 0, '0, 1, 64'h8000_2800, 0);
        tick(0, 0, '0, 1, 64'h8000_3000, 0);
        check("t5_stale", 128'(ireq_addr), 128'(64'h8000_2000));
        tick(0, 1, 32'hCAFE_F00D, 0, '0, 0);
        check("t5_addr", 128'(ireq_addr), 128'(64'h8000_3000));

        // 6: reset while in HOLD
        tick(0, 1, 32'h0000_0013, 0, '0, 0);
        tick(0, 1, 32'h0000_0013, 0, '0, 1);
        tick(1, 0, '0, 0, '0, 1);
        check("t6_valid", 128'(dataF_valid), 128'(0));
        check("t6_ireq", 128'(ireq_valid), 128'(0));
        tick(0, 0, '0, 0, '0, 0);
        check("t6_addr", 128'(ireq_addr), 128'(64'h8000_0000));

        // PC wrap-around
        tick(0, 0, '0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        tick(0, 1, 32'h0000_0001, 0, '0, 0);
        tick(0, 1, 32'h0000_0002, 0, '0, 0);
        check("wrap_addr", 128'(ireq_addr), 128'(64'h0));
        check("wrap_pc", 128'(dataF.pc), 128'(64'hFFFF_FFFF_FFFF_FFFC));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit rst, ok, rv, st;
            logic [63:0] rpc;
            rst = ($urandom_range(0, 199) == 0);
            st  = ($urandom_range(0, 2) == 0);
            ok  = !rst && (m_buf.size() == 0) && ($urandom_range(0, 1) == 1);
            rv  = !rst && ($urandom_range(0, 9) == 0);
            if (rv && ok && m_stale) rv = 0;
            rpc = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                              : {$urandom(), $urandom()};
            tick(rst, ok, $urandom(), rv, rpc, st);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
Instruction-fetch stage, directly upstream of decode. It owns the PC and issues one instruction-bus request at a time. It delivers each returned 32-bit instruction and its PC to decode through a registered fetch_data_t output with a valid bit. It also handles downstream stall and branch/jump redirect, including redirects that arrive while a bus request is in flight.

Parameters:
PC_RESET, 64'h8000_0000, PC value loaded on reset
PC_STEP, 4, PC increment per sequential instruction

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ireq_valid  out  1  instruction-bus request valid
ireq_addr  out  64  request address; equals current fetch PC
iresp_data_ok  in  1  bus response valid; one pulse per request
iresp_data  in  32  returned instruction, valid when iresp_data_ok=1
redirect_valid  in  1  redirect request from execute (branch/jump taken)
redirect_pc  in  64  redirect target
stall  in  1  decode cannot accept this cycle
dataF  out  fetch_data_t  {raw_instr[31:0], pc[63:0]} to decode
dataF_valid  out  1  dataF holds a live instruction

Behaviour:
- Reset (synchronous, active-high; clock and reset ports are clk and reset):
  - pc=PC_RESET, state=FETCH, dataF=0, dataF_valid=0, skid buffer empty.
  - ireq_valid is forced 0 while reset=1.
- Output register:
  - out_free = !dataF_valid || !stall.
  - When out_free and nothing is loaded, dataF_valid clears on the next edge.
- FETCH state:
  - ireq_valid=1, ireq_addr=pc.
  - ireq_addr must stay stable until iresp_data_ok.
  - On iresp_data_ok with out_free: next edge dataF={iresp_data,pc}, dataF_valid=1, pc+=PC_STEP, stay FETCH.
  - On iresp_data_ok with !out_free: capture {iresp_data,pc} into the skid buffer, pc+=PC_STEP, go HOLD.
- HOLD state:
  - ireq_valid=0.
  - When out_free: move the skid buffer into dataF, dataF_valid=1, go FETCH.
- DRAIN state (request in flight is stale):
  - ireq_valid=1, ireq_addr = the old (stale) address.
  - On iresp_data_ok: discard the data, go FETCH (pc already holds the target).
- Redirect (redirect_valid=1) overrides stall and all other actions:
  - Next edge: dataF_valid=0, pc=redirect_pc, skid buffer cleared.
  - From FETCH without iresp_data_ok: go DRAIN; the stale address is retained internally.
  - From FETCH with iresp_data_ok the same cycle: discard the data, stay FETCH.
  - From HOLD: go FETCH.
  - From DRAIN: update pc, stay DRAIN; the stale address is unchanged.
- Latency: iresp_data_ok to dataF_valid is 1 cycle. A redirect produces a new request no earlier than the cycle after the redirect; in DRAIN, only after the stale response returns.
- At most one outstanding request. Responses arriving in HOLD are a bus protocol error and are ignored.
- PC arithmetic is modulo 2^64; wrap-around is silent.
- No alignment check; redirect_pc is issued as given.
- Reset asserted mid-request (any state): return to the reset values. A late response after reset is not expected; the bus is reset together with this block.

Decomposition:
- pipes package: fetch_data_t {u32 raw_instr; u64 pc} (extends the existing struct) and fetch_state_t enum {FETCH, HOLD, DRAIN}.
- common package: PC_RESET default constant, plus ibus_req_t/ibus_resp_t if the bus is bundled.
- One natural sub-module: fetch_skid, a one-entry buffer with load/unload/clear, holding {instr,pc} and a valid bit.

Test Plan:
1. Reset then data_ok every cycle with instr 0x00000013, stall=0 -> ireq_addr 8000_0000, 8000_0004, 8000_0008 on successive requests; dataF_valid=1 from cycle after first data_ok; dataF.pc tracks.
2. dataF_valid=1 and stall=1 when data_ok returns 0x00100093 at pc 8000_0004 -> HOLD, ireq_valid=0. Release stall -> dataF holds 8000_0004/0x00100093 one cycle later, then request 8000_0008.
3. Redirect to 8000_1000 while request to 8000_0008 is outstanding, data_ok 3 cycles later -> ireq_addr stays 8000_0008 until data_ok, data discarded, dataF_valid=0 throughout, next request 8000_1000.
4. Redirect to 8000_2000 in the same cycle as data_ok -> response dropped; next-cycle request 8000_2000; dataF_valid=0.
5. Second redirect to 8000_3000 during DRAIN -> stale response dropped; next request 8000_3000, not 8000_2000.
6. reset=1 while in HOLD with stall=1 -> next cycle dataF_valid=0, ireq_valid=0; after release, request 8000_0000.
